// File: rtl/player_y_ctrl.sv
// Vertical motion controller for the climber sprite: stand/rise/fall/out FSM on a divided tick.
// Optional PLAYER_JUMP_LATCH_EN keeps a short jump press alive until the next tick edge.
module player_y_ctrl #(
   parameter logic [19:0] TICK_DIV    = 20'd420000,
   parameter logic [9:0]  PLAYER_H    = 10'd32,
   parameter logic [9:0]  JUMP_HEIGHT = 10'd60,
   parameter logic [9:0]  SCREEN_H    = 10'd480
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       jump,
   input  logic [9:0] plataform_start,
   input  logic [9:0] plataform_end,
   output logic [9:0] player_y,
   output logic [1:0] state,
   output logic       on_plataform,
   output logic       fell_off
);

   typedef enum logic [1:0] {
      StStand = 2'd0,
      StRise  = 2'd1,
      StFall  = 2'd2,
      StOut   = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [19:0] tick_cnt_q;
   logic [9:0]  player_y_q, player_y_d;
   logic [9:0]  rise_cnt_q, rise_cnt_d;
   logic        fell_off_q, fell_off_d;
   logic        tick;
   logic        jump_req;
   logic [10:0] feet;
   logic [9:0]  snap_y;
   logic [9:0]  dec_y;
   logic [9:0]  rise_inc;

   assign tick     = (tick_cnt_q == TICK_DIV);
   assign feet     = {1'b0, player_y_q} + {1'b0, PLAYER_H};
   assign snap_y   = (plataform_start >= PLAYER_H) ? (plataform_start - PLAYER_H) : 10'd0;
   assign dec_y    = (player_y_q != 10'd0) ? (player_y_q - 10'd1) : 10'd0;
   assign rise_inc = rise_cnt_q + 10'd1;

`ifdef PLAYER_JUMP_LATCH_EN
   logic jump_prev_q;
   logic jump_latch_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         jump_prev_q  <= 1'b0;
         jump_latch_q <= 1'b0;
      end else begin
         jump_prev_q <= jump;
         if (tick) begin
            jump_latch_q <= 1'b0;
         end else if (jump && !jump_prev_q) begin
            jump_latch_q <= 1'b1;
         end
      end
   end

   // An edge on the tick edge itself is covered by the live level of jump.
   assign jump_req = jump_latch_q | jump;
`else
   assign jump_req = jump;
`endif

   always_comb begin
      state_d    = state_q;
      player_y_d = player_y_q;
      rise_cnt_d = rise_cnt_q;
      if (tick) begin
         unique case (state_q)
            StStand: begin
               if (jump_req) begin
                  state_d    = StRise;
                  rise_cnt_d = 10'd0;
               end else if (plataform_start >= SCREEN_H) begin
                  state_d = StOut;
               end else begin
                  player_y_d = snap_y;
               end
            end
            StRise: begin
               player_y_d = dec_y;
               rise_cnt_d = rise_inc;
               if ((rise_inc >= JUMP_HEIGHT) || (dec_y == 10'd0)) begin
                  state_d = StFall;
               end
            end
            StFall: begin
               if (({1'b0, plataform_start} <= feet) && (feet <= {1'b0, plataform_end})) begin
                  player_y_d = snap_y;
                  state_d    = StStand;
               end else if (feet >= {1'b0, SCREEN_H}) begin
                  state_d = StOut;
               end else begin
                  player_y_d = player_y_q + 10'd1;
               end
            end
            StOut: begin
               if (jump_req) begin
                  player_y_d = 10'd0;
                  state_d    = StFall;
               end
            end
            default: state_d = StFall;
         endcase
      end
      fell_off_d = tick && (state_q != StOut) && (state_d == StOut);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt_q <= 20'd0;
         state_q    <= StFall;
         player_y_q <= 10'd0;
         rise_cnt_q <= 10'd0;
         fell_off_q <= 1'b0;
      end else begin
         tick_cnt_q <= tick ? 20'd0 : (tick_cnt_q + 20'd1);
         state_q    <= state_d;
         player_y_q <= player_y_d;
         rise_cnt_q <= rise_cnt_d;
         fell_off_q <= fell_off_d;
      end
   end

   assign player_y     = player_y_q;
   assign state        = state_q;
   assign on_plataform = (state_q == StStand);
   assign fell_off     = fell_off_q;

endmodule

// File: tb/tb_player_y_ctrl.sv
// Directed, table-driven bench for player_y_ctrl with a 4-cycle tick.
// Hand sequences cover reset mid-fall, mid-period platform change, fell_off width and jump latch.
module tb_player_y_ctrl;

   logic       clk;
   logic       rst_n;
   logic       jump;
   logic [9:0] plataform_start;
   logic [9:0] plataform_end;
   logic [9:0] player_y;
   logic [1:0] state;
   logic       on_plataform;
   logic       fell_off;

   int compared;
   int mismatched;

   typedef struct {
      logic       jump;
      logic [9:0] ps;
      logic [9:0] pe;
      int         ticks;
      logic [9:0] y;
      logic [1:0] st;
      logic       onp;
      logic       fell;
   } vec_t;

   vec_t vecs[14];

   player_y_ctrl #(
      .TICK_DIV    (20'd3),
      .PLAYER_H    (10'd32),
      .JUMP_HEIGHT (10'd60),
      .SCREEN_H    (10'd480)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .jump            (jump),
      .plataform_start (plataform_start),
      .plataform_end   (plataform_end),
      .player_y        (player_y),
      .state           (state),
      .on_plataform    (on_plataform),
      .fell_off        (fell_off)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string name, input logic [9:0] y, input logic [1:0] st,
                            input logic onp, input logic fell);
      check({name, ".player_y"}, 32'(player_y), 32'(y));
      check({name, ".state"}, 32'(state), 32'(st));
      check({name, ".on_plataform"}, 32'(on_plataform), 32'(onp));
      check({name, ".fell_off"}, 32'(fell_off), 32'(fell));
   endtask

   // Each row starts right after a tick edge and advances whole tick periods.
   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         jump            = vecs[i].jump;
         plataform_start = vecs[i].ps;
         plataform_end   = vecs[i].pe;
         cycles(4 * vecs[i].ticks);
         check_all($sformatf("row%0d", i), vecs[i].y, vecs[i].st, vecs[i].onp, vecs[i].fell);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;

      //             jump  ps       pe       ticks y       st    onp   fell
      vecs[0]  = '{1'b0, 10'd100, 10'd130, 1,  10'd1,  2'd2, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 10'd100, 10'd130, 67, 10'd68, 2'd2, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 10'd100, 10'd130, 1,  10'd68, 2'd0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 10'd100, 10'd130, 1,  10'd68, 2'd0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 10'd100, 10'd130, 1,  10'd68, 2'd1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 10'd100, 10'd130, 59, 10'd9,  2'd1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 10'd100, 10'd130, 1,  10'd8,  2'd2, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 10'd100, 10'd130, 60, 10'd68, 2'd2, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 10'd100, 10'd130, 1,  10'd68, 2'd0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 10'd480, 10'd500, 1,  10'd68, 2'd3, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 10'd480, 10'd500, 1,  10'd68, 2'd3, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 10'd480, 10'd500, 1,  10'd0,  2'd2, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 10'd40,  10'd60,  8,  10'd8,  2'd2, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 10'd40,  10'd60,  1,  10'd8,  2'd0, 1'b1, 1'b0};

      rst_n           = 1'b0;
      jump            = 1'b0;
      plataform_start = 10'd400;
      plataform_end   = 10'd410;

      // Reset in the middle of a fall.
      cycles(3);
      rst_n = 1'b1;
      cycles(4 * 40);
      check("fall40.player_y", 32'(player_y), 32'd40);
      cycles(2);
      rst_n = 1'b0;
      cycles(2);
      check_all("reset", 10'd0, 2'd2, 1'b0, 1'b0);
      rst_n = 1'b1;
      cycles(3);
      check("rel3.player_y", 32'(player_y), 32'd0);
      cycles(1);
      check("rel4.player_y", 32'(player_y), 32'd1);

      // Fresh start for landing.
      rst_n = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      run_rows(0, 3);

      // Riding: platform moves mid-period, position follows only on the tick edge.
      cycles(2);
      plataform_start = 10'd101;
      plataform_end   = 10'd131;
      cycles(1);
      check("ride_mid.player_y", 32'(player_y), 32'd68);
      cycles(1);
      check("ride_tick.player_y", 32'(player_y), 32'd69);
      check("ride_tick.state", 32'(state), 32'd0);
      plataform_start = 10'd100;
      plataform_end   = 10'd130;
      cycles(4);
      check("ride_back.player_y", 32'(player_y), 32'd68);

      // Jump, re-land, then fall off.
      run_rows(4, 9);
      cycles(1);
      check("fell_off_width", 32'(fell_off), 32'd0);
      cycles(3);
      run_rows(10, 13);

      // Short jump pulse two cycles before a tick edge.
      cycles(1);
      jump = 1'b1;
      cycles(1);
      jump = 1'b0;
      cycles(2);
`ifdef PLAYER_JUMP_LATCH_EN
      check("latch.state", 32'(state), 32'd1);
      check("latch.on_plataform", 32'(on_plataform), 32'd0);
`else
      check("latch.state", 32'(state), 32'd0);
      check("latch.on_plataform", 32'(on_plataform), 32'd1);
`endif
      check("latch.player_y", 32'(player_y), 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
